verdict_stream_serializer: RTL and testbench
============================================

// Module: verdict_stream_serializer
// PURPOSE
// Sink-side counterpart to the input-event driver of the generated monitor (topEntity).
// - Samples the monitor's output values and *_aktv flags every cycle.
// - Stores each cycle that has at least one active output as a timestamped snapshot in a FIFO.
// - Serializes each snapshot into one record per active output over a valid/ready stream.
// - Sits between topEntity and the host/trace logger.
// PARAMETERS
// NUM_OUTPUTS  9   number of monitor output streams (1..16)
// DATA_W       64  width of each output value (signed, passed through unchanged)
// TS_W         32  timestamp counter width
// DEPTH        16  snapshot FIFO depth (power of 2, >=2)
// IDX_W        4   width of the record output-index field; 2^IDX_W >= NUM_OUTPUTS
// PORTS
// clk        in   1                  system clock, rising edge
// rst        in   1                  synchronous reset, active-low
// en         in   1                  block enable (same signal as the monitor's en)
// out_vals   in   NUM_OUTPUTS*DATA_W monitor outputs, output_k at bits [k*DATA_W +: DATA_W]
// out_aktv   in   NUM_OUTPUTS        bit k = output_k_aktv
// rec_valid  out  1                  record available
// rec_ready  in   1                  consumer accepts record
// rec_ts     out  TS_W               timestamp of the snapshot
// rec_idx    out  IDX_W              output index k of this record
// rec_value  out  DATA_W             value of output_k
// rec_last   out  1                  last record of the snapshot
// ovf_cnt    out  16                 dropped-snapshot count, saturating
// BEHAVIOUR
// - Reset (rst==0 at a rising edge):
//   - ts counter = 0; FIFO is emptied; FSM goes to IDLE.
//   - rec_valid=0, rec_last=0, rec_ts/rec_idx/rec_value=0, ovf_cnt=0.
//   - Reset mid-record discards the in-flight snapshot with no partial handshake.
// - en==0: no state changes; counter, FIFO and FSM hold; rec_* outputs hold their values.
//   No transfer occurs even when rec_valid && rec_ready.
// - Timestamp: ts increments by 1 on every edge with en==1 and wraps modulo 2^TS_W.
//   A snapshot takes the ts value present before that edge's increment.
// - Capture: on an edge with en==1 and |out_aktv, push {ts, out_aktv, out_vals}.
//   Cycles where out_aktv==0 are never stored.
// - FIFO full at capture:
//   - If the serializer pops on the same edge, the write is accepted.
//   - Otherwise the snapshot is dropped and ovf_cnt += 1, saturating at 16'hFFFF.
// - FSM states: IDLE, EMIT.
//   - IDLE: if the FIFO is non-empty, pop the head into the working registers {ts, mask, vals}, go to EMIT.
//   - EMIT: rec_valid=1.
//     - rec_idx = lowest set bit k of mask; rec_value = vals[k]; rec_ts = snapshot ts.
//     - rec_last = 1 iff mask has exactly one bit set.
//     - On handshake (rec_valid && rec_ready && en): clear bit k. If it was the last bit, rec_valid=0 and go to IDLE.
//     - rec_* outputs stay stable while rec_valid && !rec_ready.
// - Latency:
//   - Capture edge E0 writes the FIFO. Edge E1 pops it (FIFO was empty, FSM in IDLE).
//   - rec_valid is high after E1.
//   - After rec_last is accepted there is one bubble cycle (IDLE) before the next snapshot.
// - Throughput: records are emitted in ascending index order within a snapshot; snapshots leave in FIFO order.
// - Widths: values are passed through bit-exact with no sign handling. rec_idx is zero-extended to IDX_W.
// TESTING
// - Reset, then in cycle 5 apply aktv=9'h001 with output_0=1, rec_ready=1.
//   -> one record: ts=5, idx=0, value=1, last=1; rec_valid high exactly 1 cycle.
// - aktv=9'h105, output_0=-3, output_2=7, output_8=42, rec_ready=1.
//   -> three records idx 0,2,8; values -3,7,42; same ts; last=1 only on idx 8.
// - rec_ready=0 for 40 cycles while 20 single-output snapshots arrive (DEPTH=16).
//   -> ovf_cnt counts the snapshots dropped after the FIFO holds 16 plus the working register.
//   -> after rec_ready=1, the accepted snapshots drain in order with strictly increasing ts.
// - Randomly toggle rec_ready with backpressure mid-snapshot.
//   -> rec_* stay stable while stalled; no record is lost or duplicated (scoreboard vs. driven aktv/values).
// - Assert rst=0 during EMIT of a 3-record snapshot.
//   -> next cycle rec_valid=0, ovf_cnt=0, FIFO empty; the first post-reset snapshot has ts equal to its cycle count from reset.
// - Preload ts to 2^TS_W-2 with TS_W=4 override, two consecutive snapshots across the wrap.
//   -> ts values 14 then 15, then 0 on the next captured cycle.

Source files
------------

// File: rtl/verdict_stream_serializer.sv
// verdict_stream_serializer
// Samples the monitor outputs every enabled cycle. Each cycle with at least
// one active output is stored as a timestamped snapshot in a FIFO. Snapshots
// are then serialized as one record per active output, in ascending index
// order, over a valid/ready stream toward the host/trace logger.
//
// Handshake: a record transfers on a rising edge where rec_valid, rec_ready
// and en are all high. While rec_valid is high and the record is not taken,
// rec_ts/rec_idx/rec_value/rec_last do not change. rec_valid is never
// withdrawn except by reset.
module verdict_stream_serializer #(
  parameter int NUM_OUTPUTS = 9,
  parameter int DATA_W      = 64,
  parameter int TS_W        = 32,
  parameter int DEPTH       = 16,
  parameter int IDX_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_OUTPUTS*DATA_W-1:0] out_vals,
  input  logic [NUM_OUTPUTS-1:0]        out_aktv,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [TS_W-1:0]               rec_ts,
  output logic [IDX_W-1:0]              rec_idx,
  output logic [DATA_W-1:0]             rec_value,
  output logic                          rec_last,
  output logic [15:0]                   ovf_cnt
);

  localparam int AW     = $clog2(DEPTH);
  localparam int VALS_W = NUM_OUTPUTS * DATA_W;
  localparam int SNAP_W = TS_W + NUM_OUTPUTS + VALS_W;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Free-running timestamp and snapshot storage.
  logic [TS_W-1:0]   ts;
  logic [SNAP_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full;

  // Snapshot currently being serialized.
  logic [TS_W-1:0]        w_ts;
  logic [NUM_OUTPUTS-1:0] w_mask;
  logic [VALS_W-1:0]      w_vals;

  // Control strobes for the current edge.
  logic capture, push, pop, drop, fire;

  // Lowest pending output of the working snapshot.
  logic [IDX_W-1:0]       low_idx;
  logic [NUM_OUTPUTS-1:0] low_bit;
  logic [DATA_W-1:0]      low_val;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO still accepts a capture when the serializer frees a slot on
  // the same edge; otherwise the snapshot is dropped and counted.
  assign capture = en && (|out_aktv);
  assign push    = capture && (!fifo_full || pop);
  assign drop    = capture && fifo_full && !pop;

  // Find the lowest set bit of the pending mask; scanning downward lets the
  // lowest match win.
  always_comb begin
    low_idx = '0;
    low_bit = '0;
    low_val = '0;
    for (int k = NUM_OUTPUTS - 1; k >= 0; k--) begin
      if (w_mask[k]) begin
        low_idx    = IDX_W'(k);
        low_bit    = '0;
        low_bit[k] = 1'b1;
        low_val    = w_vals[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and strobe logic for the serializer FSM.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (en && !fifo_empty) begin
          pop       = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (en && rec_ready) begin
          fire = 1'b1;
          if (w_mask == low_bit) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Record outputs come straight from the working registers, so they hold
  // whenever those registers hold (stall, en low).
  always_comb begin
    rec_valid = (state == EMIT);
    rec_last  = (state == EMIT) && (w_mask == low_bit);
    rec_ts    = w_ts;
    rec_idx   = low_idx;
    rec_value = low_val;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timestamp counter: advances on every enabled edge, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ts <= '0;
    end else if (en) begin
      ts <= ts + TS_W'(1);
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {ts, out_aktv, out_vals};
    end
  end

  // Working snapshot: loaded on pop, one mask bit retired per accepted record.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_ts   <= '0;
      w_mask <= '0;
      w_vals <= '0;
    end else if (pop) begin
      {w_ts, w_mask, w_vals} <= mem[rd_ptr[AW-1:0]];
    end else if (fire) begin
      w_mask <= w_mask & ~low_bit;
    end
  end

  // Saturating count of snapshots lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_verdict_stream_serializer.sv
// Bench for verdict_stream_serializer: directed snapshots with hand-computed
// records, overflow, backpressure, mid-record reset and timestamp wrap.
module tb_verdict_stream_serializer;

  localparam int N     = 9;
  localparam int DW    = 64;
  localparam int TW    = 32;
  localparam int IW    = 4;
  localparam int REC_W = TW + IW + DW + 1;

  // ---------------- clock / reset / signals ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b1;
  logic            rec_ready = 1'b0;
  logic [N*DW-1:0] out_vals = '0;
  logic [N-1:0]    out_aktv = '0;
  logic            rec_valid;
  logic [TW-1:0]   rec_ts;
  logic [IW-1:0]   rec_idx;
  logic [DW-1:0]   rec_value;
  logic            rec_last;
  logic [15:0]     ovf_cnt;

  logic            rst4 = 1'b0;
  logic [N-1:0]    aktv4 = '0;
  logic            rec_valid4;
  logic [3:0]      rec_ts4;
  logic [IW-1:0]   rec_idx4;
  logic [DW-1:0]   rec_value4;
  logic            rec_last4;
  logic [15:0]     ovf_cnt4;

  always #5 clk = ~clk;

  verdict_stream_serializer u_dut (
    .clk(clk), .rst(rst), .en(en), .out_vals(out_vals), .out_aktv(out_aktv),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ts(rec_ts),
    .rec_idx(rec_idx), .rec_value(rec_value), .rec_last(rec_last),
    .ovf_cnt(ovf_cnt)
  );

  verdict_stream_serializer #(.TS_W(4)) u_dut4 (
    .clk(clk), .rst(rst4), .en(en), .out_vals(out_vals), .out_aktv(aktv4),
    .rec_valid(rec_valid4), .rec_ready(1'b1), .rec_ts(rec_ts4),
    .rec_idx(rec_idx4), .rec_value(rec_value4), .rec_last(rec_last4),
    .ovf_cnt(ovf_cnt4)
  );

  // ---------------- scoreboard state ----------------
  int              n_checks = 0;
  int              n_errors = 0;
  logic [REC_W-1:0] exp_q[$];
  logic [3:0]      ts4_q[$];
  int unsigned     cyc = 0;
  bit              rand_ready = 1'b0;
  bit              rand_en = 1'b0;
  int              valid_cycles = 0;
  logic [DW-1:0]   vals_arr [N];
  logic [REC_W-1:0] cur, prev;
  bit              stall_prev = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (rst && en) cyc++;
    #1;
    if (rand_ready) rec_ready = 1'($urandom_range(0, 1));
    if (rand_en) en = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    out_aktv = '0;
    tick();
    tick();
    rst = 1'b1;
    cyc = 0;
  endtask

  // Present one snapshot for a single edge; with keep set, the records it
  // should produce are queued (ascending index, last on highest index).
  task automatic snap(input logic [N-1:0] aktv, input bit keep);
    int hi;
    hi = -1;
    for (int k = 0; k < N; k++) begin
      out_vals[k*DW +: DW] = vals_arr[k];
      if (aktv[k]) hi = k;
    end
    out_aktv = aktv;
    if (keep && en && (aktv != '0)) begin
      for (int k = 0; k < N; k++) begin
        if (aktv[k]) exp_q.push_back({TW'(cyc), IW'(k), vals_arr[k], (k == hi)});
      end
    end
    tick();
    out_aktv = '0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
    check("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    cur = {rec_ts, rec_idx, rec_value, rec_last};
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (rec_valid) valid_cycles++;
      if (stall_prev) check("stable", cur, prev);
      if (en && rec_valid && rec_ready) begin
        if (exp_q.size() == 0) check("rec_extra", exp_q.size(), 1);
        else check("rec", cur, exp_q.pop_front());
      end
      stall_prev = rec_valid && !(en && rec_ready);
      prev = cur;
    end
  end

  always @(negedge clk) begin
    if (rst4 && en && rec_valid4) ts4_q.push_back(rec_ts4);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] m;
    for (int k = 0; k < N; k++) vals_arr[k] = '0;

    // Reset state
    do_reset();
    check("rst_valid", rec_valid, 0);
    check("rst_last", rec_last, 0);
    check("rst_ts", rec_ts, 0);
    check("rst_idx", rec_idx, 0);
    check("rst_value", rec_value, 0);
    check("rst_ovf", ovf_cnt, 0);

    // Single output captured in cycle 5
    rec_ready = 1'b1;
    repeat (5) tick();
    vals_arr[0] = 64'd1;
    valid_cycles = 0;
    exp_q.push_back({32'd5, 4'd0, 64'd1, 1'b1});
    snap(9'h001, 1'b0);
    repeat (6) tick();
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_drain", exp_q.size(), 0);

    // Three outputs in one snapshot
    for (int k = 0; k < N; k++) vals_arr[k] = 64'hDEAD_BEEF;
    vals_arr[0] = 64'hFFFF_FFFF_FFFF_FFFD;
    vals_arr[2] = 64'd7;
    vals_arr[8] = 64'd42;
    exp_q.push_back({TW'(cyc), 4'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
    exp_q.push_back({TW'(cyc), 4'd2, 64'd7, 1'b0});
    exp_q.push_back({TW'(cyc), 4'd8, 64'd42, 1'b1});
    snap(9'h105, 1'b0);
    wait_drain(20);

    // Overflow: 20 back-to-back snapshots, consumer stalled for 40 cycles.
    // 1 in the working register + 16 queued are kept, 3 dropped.
    rec_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      m = 9'(1) << (i % N);
      vals_arr[i % N] = 64'(100 + i);
      snap(m, (i < 17));
    end
    repeat (20) tick();
    check("t3_ovf", ovf_cnt, 3);
    check("t3_head_valid", rec_valid, 1);
    check("t3_head_value", rec_value, 100);
    rec_ready = 1'b1;
    wait_drain(200);

    // Random backpressure and enable gaps
    rand_ready = 1'b1;
    rand_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < N; k++) vals_arr[k] = {$urandom, $urandom};
      m = 9'($urandom_range(1, 511));
      snap(m, 1'b1);
      repeat ($urandom_range(8, 14)) tick();
    end
    rand_ready = 1'b0;
    rand_en = 1'b0;
    en = 1'b1;
    rec_ready = 1'b1;
    wait_drain(600);
    check("t4_ovf", ovf_cnt, 3);

    // Reset in the middle of a 3-record snapshot with another queued
    rec_ready = 1'b0;
    for (int k = 0; k < N; k++) vals_arr[k] = 64'(k + 1);
    snap(9'h007, 1'b0);
    snap(9'h030, 1'b0);
    tick();
    check("t5_pre_valid", rec_valid, 1);
    rst = 1'b0;
    tick();
    exp_q.delete();
    check("t5_rst_valid", rec_valid, 0);
    check("t5_rst_ovf", ovf_cnt, 0);
    check("t5_rst_ts", rec_ts, 0);
    rst = 1'b1;
    cyc = 0;
    rec_ready = 1'b1;
    repeat (4) tick();
    check("t5_fifo_empty", rec_valid, 0);
    exp_q.push_back({32'd4, 4'd4, 64'd5, 1'b1});
    snap(9'h010, 1'b0);
    wait_drain(20);

    // Timestamp wrap on the 4-bit instance
    rst4 = 1'b1;
    repeat (14) tick();
    aktv4 = 9'h001;
    repeat (3) tick();
    aktv4 = '0;
    repeat (12) tick();
    check("t6_count", ts4_q.size(), 3);
    if (ts4_q.size() >= 3) begin
      check("t6_ts0", ts4_q[0], 14);
      check("t6_ts1", ts4_q[1], 15);
      check("t6_ts2", ts4_q[2], 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
